apb_timer_seq: RTL and testbench

//  APB master sequencer that owns the 4-register APB timer slave. Turns one-shot

---
 rtl/apb_timer_seq.sv | 163 ++++++++++++++++
 tb/tb_apb_timer_seq.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_seq.sv
// apb_timer_seq: APB master sequencer for the 4-register timer, with host command and auto interrupt-clear arbitration
module apb_timer_seq #(
  parameter bit AUTO_CLR = 1'b1,
  parameter int TO_CYC   = 64,
  parameter int CNT_W    = 16
) (
  input  logic             PCLKGated,
  input  logic             PRESETn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_data,
  input  logic             cmd_ien,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  input  logic             int_timer,
  output logic             irq_evt,
  output logic [CNT_W-1:0] irq_cnt,
  output logic             busy,
  output logic             m_psel,
  output logic             m_penable,
  output logic             m_pwrite,
  output logic [1:0]       m_paddr,
  output logic [31:0]      m_pwdata,
  input  logic [31:0]      m_prdata,
  input  logic             m_pready,
  input  logic             m_pslverr
);
  localparam int WW = $clog2(TO_CYC + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  typedef struct packed {
    logic        last;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
  } step_t;
  state_t        state;
  logic [2:0]    op_q;
  logic [31:0]   data_q;
  logic          ien_q;
  logic          auto_q;
  logic          last_q;
  logic          err_q;
  logic [1:0]    idx;
  logic [WW-1:0] wcnt;
  logic [2:0]    hold;
  logic          svc;
  step_t         first;
  step_t         nxt;
  // Step table: op 5 doubles as the auto-service interrupt clear.
  function automatic step_t step_of(input logic [2:0] op, input logic [1:0] i,
                                    input logic [31:0] d, input logic ien);
    step_t s;
    s = '{last: 1'b1, wr: 1'b1, addr: 2'd0, wd: 32'd0};
    case (op)
      3'd0: if (i == 2'd0) s = '{last: 1'b0, wr: 1'b1, addr: 2'd1, wd: d};
            else if (i == 2'd1) s = '{last: 1'b0, wr: 1'b1, addr: 2'd2, wd: 32'd4};
            else s.wd = {30'd0, ien, 1'b1};
      3'd1: s.wd = 32'd0;
      3'd2: if (i == 2'd0) s = '{last: 1'b0, wr: 1'b1, addr: 2'd1, wd: d};
            else s = '{last: 1'b1, wr: 1'b1, addr: 2'd2, wd: 32'd4};
      3'd3: s = '{last: 1'b1, wr: 1'b0, addr: 2'd3, wd: 32'd0};
      3'd4: s = '{last: 1'b1, wr: 1'b0, addr: 2'd2, wd: 32'd0};
      default: s = '{last: 1'b1, wr: 1'b1, addr: 2'd2, wd: 32'd1};
    endcase
    return s;
  endfunction
  assign svc       = AUTO_CLR && int_timer && hold == 3'd0;
  assign first     = step_of(svc ? 3'd5 : cmd_op, 2'd0, cmd_data, cmd_ien);
  assign nxt       = step_of(op_q, idx + 2'd1, data_q, ien_q);
  assign cmd_ready = state == IDLE && !svc;
  assign busy      = state != IDLE;
  always_ff @(posedge PCLKGated or negedge PRESETn)
    if (!PRESETn) begin
      state     <= IDLE;
      op_q      <= '0;
      data_q    <= '0;
      ien_q     <= 1'b0;
      auto_q    <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      idx       <= '0;
      wcnt      <= '0;
      hold      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      irq_evt   <= 1'b0;
      irq_cnt   <= '0;
      m_psel    <= 1'b0;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      irq_evt   <= 1'b0;
      if (hold != 3'd0) hold <= hold - 3'd1;
      case (state)
        IDLE: if (svc || cmd_valid) begin
          op_q   <= svc ? 3'd5 : cmd_op;
          auto_q <= svc;
          data_q <= cmd_data;
          ien_q  <= cmd_ien;
          err_q  <= 1'b0;
          idx    <= '0;
          if (!svc && cmd_op > 3'd5) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else begin
            state    <= SETUP;
            m_psel   <= 1'b1;
            m_pwrite <= first.wr;
            m_paddr  <= first.addr;
            m_pwdata <= first.wd;
            last_q   <= first.last;
          end
        end
        SETUP: begin
          m_penable <= 1'b1;
          wcnt      <= '0;
          state     <= ACCESS;
        end
        ACCESS: if (m_pready) begin
          m_penable <= 1'b0;
          // Interrupt deassertion reaches us late; mask it after any clear.
          if (m_pwrite && m_paddr == 2'd2 && m_pwdata[0]) hold <= 3'd4;
          if (!last_q) begin
            idx      <= idx + 2'd1;
            m_pwrite <= nxt.wr;
            m_paddr  <= nxt.addr;
            m_pwdata <= nxt.wd;
            last_q   <= nxt.last;
            err_q    <= err_q | m_pslverr;
            state    <= SETUP;
          end else begin
            m_psel <= 1'b0;
            if (auto_q) begin
              irq_evt <= 1'b1;
              if (~&irq_cnt) irq_cnt <= irq_cnt + CNT_W'(1);
              state <= IDLE;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= err_q | m_pslverr;
              rsp_data  <= m_pwrite ? 32'd0 : m_prdata;
              state     <= RESP;
            end
          end
        end else if (wcnt == WW'(TO_CYC - 1)) begin
          m_psel    <= 1'b0;
          m_penable <= 1'b0;
          state     <= auto_q ? IDLE : RESP;
          rsp_valid <= !auto_q;
          rsp_err   <= !auto_q;
        end else wcnt <= wcnt + WW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_timer_seq.sv
// tb_apb_timer_seq: randomized and directed checks of apb_timer_seq against a register-effect model
module tb_apb_timer_seq;
  logic        clk = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ien = 1'b0;
  logic        int_timer = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_err, irq_evt, busy;
  logic [31:0] rsp_data;
  logic [1:0]  irq_cnt;
  logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
  logic [1:0]  m_paddr;
  logic [31:0] m_pwdata, m_prdata;
  int vectors = 0, miscompares = 0;
  int acc_cyc = 0, stall_addr = -1, stall_cyc = 0, slverr_addr = -1;
  int evt_count = 0, psel_cycles = 0, rsp_count = 0, exp_lat = 0;
  logic stuck = 1'b0;
  logic [31:0] rd_regs [4];
  logic [33:0] log_q[$], exp_q[$];
  logic exp_rd;
  logic [1:0] exp_rd_a;
  logic [1:0] s_a;
  logic [31:0] s_d;
  logic s_w;

  apb_timer_seq #(.AUTO_CLR(1'b1), .TO_CYC(8), .CNT_W(2)) dut (
    .PCLKGated(clk), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ien(cmd_ien), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .int_timer(int_timer), .irq_evt(irq_evt),
    .irq_cnt(irq_cnt), .busy(busy), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  always #5 clk = ~clk;
  assign m_pready  = !stuck && acc_cyc >= ((int'(m_paddr) == stall_addr) ? stall_cyc : 0);
  assign m_pslverr = int'(m_paddr) == slverr_addr;
  assign m_prdata  = rd_regs[m_paddr];

  always @(posedge clk) begin
    acc_cyc <= (m_psel && m_penable && !m_pready) ? acc_cyc + 1 : 0;
    if (m_psel && m_penable && m_pready && m_pwrite) log_q.push_back({m_paddr, m_pwdata});
    if (irq_evt) evt_count++;
    if (m_psel) psel_cycles++;
    if (rsp_valid) rsp_count++;
  end

  // Address, data and direction must hold from SETUP until the transfer ends.
  always @(negedge clk)
    if (m_psel && !m_penable) begin
      s_a = m_paddr; s_d = m_pwdata; s_w = m_pwrite;
    end else if (m_psel && m_penable) begin
      vectors++;
      if ({m_paddr, m_pwdata, m_pwrite} !== {s_a, s_d, s_w}) begin
        miscompares++;
        $display("FAIL stable: got a=%0d d=%h w=%b, required a=%0d d=%h w=%b", m_paddr, m_pwdata, m_pwrite, s_a, s_d, s_w);
      end
    end

  function automatic void model(input logic [2:0] op, input logic [31:0] d, input logic ien);
    exp_q.delete();
    exp_rd = 1'b0;
    exp_rd_a = 2'd0;
    case (op)
      3'd0: begin
        exp_q.push_back({2'd1, d});
        exp_q.push_back({2'd2, 32'd4});
        exp_q.push_back({2'd0, 30'd0, ien, 1'b1});
      end
      3'd1: exp_q.push_back({2'd0, 32'd0});
      3'd2: begin
        exp_q.push_back({2'd1, d});
        exp_q.push_back({2'd2, 32'd4});
      end
      3'd3: begin exp_rd = 1'b1; exp_rd_a = 2'd3; end
      3'd4: begin exp_rd = 1'b1; exp_rd_a = 2'd2; end
      default: exp_q.push_back({2'd2, 32'd1});
    endcase
    exp_lat = 1;
    foreach (exp_q[i]) exp_lat += 2 + ((int'(exp_q[i][33:32]) == stall_addr) ? stall_cyc : 0);
    if (exp_rd) exp_lat += 2 + ((int'(exp_rd_a) == stall_addr) ? stall_cyc : 0);
  endfunction

  function automatic bit log_ok();
    if (log_q.size() != exp_q.size()) return 1'b0;
    foreach (log_q[i]) if (log_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_cmd(input logic [2:0] op, input logic [31:0] d, input logic ien,
                         output int lat, output logic err, output logic [31:0] rd);
    cmd_op = op; cmd_data = d; cmd_ien = ien; cmd_valid = 1'b1;
    lat = -1; err = 1'bx; rd = 'x;
    #1;
    for (int i = 0; i < 100 && !cmd_ready; i++) begin @(negedge clk); #1; end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = i; err = rsp_err; rd = rsp_data; break; end
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (2) @(negedge clk);
    PRESETn = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, busy, m_psel, m_penable, rsp_valid, irq_evt} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b, required 100000", {cmd_ready, busy, m_psel, m_penable, rsp_valid, irq_evt});
    end
    vectors++;
    if (irq_cnt !== 2'd0 || rsp_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_val: got cnt=%0d data=%h, required 0 0", irq_cnt, rsp_data);
    end
  endtask

  task automatic test_start();
    int lat; logic err; logic [31:0] rd;
    log_q.delete();
    model(3'd0, 32'h10, 1'b1);
    run_cmd(3'd0, 32'h10, 1'b1, lat, err, rd);
    vectors++;
    if (lat !== 7 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL start_rsp: got lat=%0d err=%b, required lat=7 err=0", lat, err);
    end
    vectors++;
    if (!log_ok()) begin
      miscompares++;
      $display("FAIL start_writes: got %0d writes, required %0d (A1=10,A2=4,A0=3)", log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_stall();
    int lat; logic err; logic [31:0] rd, d;
    d = $urandom;
    stall_addr = 2; stall_cyc = 5;
    log_q.delete();
    model(3'd2, d, 1'b0);
    run_cmd(3'd2, d, 1'b0, lat, err, rd);
    vectors++;
    if (lat !== 10 || lat !== exp_lat || err !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_rsp: got lat=%0d err=%b, required lat=10 err=0", lat, err);
    end
    vectors++;
    if (!log_ok()) begin
      miscompares++;
      $display("FAIL stall_writes: got %0d writes, required %0d", log_q.size(), exp_q.size());
    end
    stall_addr = -1; stall_cyc = 0;
  endtask

  task automatic test_read();
    int lat; logic err; logic [31:0] rd;
    rd_regs[3] = 32'h1234;
    rd_regs[2] = 32'h3;
    run_cmd(3'd3, 32'h0, 1'b0, lat, err, rd);
    vectors++;
    if (lat !== 3 || err !== 1'b0 || rd !== 32'h1234) begin
      miscompares++;
      $display("FAIL rd_cnt: got lat=%0d err=%b data=%h, required 3 0 1234", lat, err, rd);
    end
    run_cmd(3'd4, 32'h0, 1'b0, lat, err, rd);
    vectors++;
    if (lat !== 3 || err !== 1'b0 || rd !== 32'h3) begin
      miscompares++;
      $display("FAIL rd_stat: got lat=%0d err=%b data=%h, required 3 0 3", lat, err, rd);
    end
  endtask

  task automatic test_arb();
    int lat; logic err; logic [31:0] rd;
    log_q.delete();
    evt_count = 0;
    exp_q.delete();
    exp_q.push_back({2'd2, 32'd1});
    exp_q.push_back({2'd0, 32'd0});
    int_timer = 1'b1;
    fork
      begin
        for (int i = 0; i < 40 && !irq_evt; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        int_timer = 1'b0;
      end
      run_cmd(3'd1, 32'h0, 1'b0, lat, err, rd);
    join
    vectors++;
    if (lat !== 3 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL arb_stop: got lat=%0d err=%b, required 3 0", lat, err);
    end
    vectors++;
    if (!log_ok()) begin
      miscompares++;
      $display("FAIL arb_order: got %0d writes, required clear then stop", log_q.size());
    end
    vectors++;
    if (irq_cnt !== 2'd1) begin
      miscompares++;
      $display("FAIL arb_cnt: got %0d, required 1", irq_cnt);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (evt_count !== 1) begin
      miscompares++;
      $display("FAIL holdoff: got %0d services, required 1", evt_count);
    end
  endtask

  task automatic test_sat();
    int exp_cnt = 1;
    int rsp0 = rsp_count;
    evt_count = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (6) @(negedge clk);
      int_timer = 1'b1;
      for (int i = 0; i < 20 && !irq_evt; i++) @(negedge clk);
      int_timer = 1'b0;
      exp_cnt = exp_cnt < 3 ? exp_cnt + 1 : 3;
      @(negedge clk);
      vectors++;
      if (irq_cnt !== 2'(exp_cnt)) begin
        miscompares++;
        $display("FAIL sat_cnt: got %0d, required %0d", irq_cnt, exp_cnt);
      end
    end
    vectors++;
    if (evt_count !== 3 || rsp_count !== rsp0) begin
      miscompares++;
      $display("FAIL sat_evt: got evt=%0d rsp=%0d, required evt=3 rsp=0", evt_count, rsp_count - rsp0);
    end
  endtask

  task automatic test_timeout();
    int lat; logic err; logic [31:0] rd;
    log_q.delete();
    stuck = 1'b1;
    run_cmd(3'd0, $urandom, 1'b1, lat, err, rd);
    vectors++;
    if (lat !== 10 || err !== 1'b1 || m_psel !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout: got lat=%0d err=%b psel=%b, required 10 1 0", lat, err, m_psel);
    end
    vectors++;
    if (log_q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_writes: got %0d writes, required 0", log_q.size());
    end
    stuck = 1'b0;
    psel_cycles = 0;
    run_cmd(3'd7, 32'h0, 1'b0, lat, err, rd);
    vectors++;
    if (lat !== 1 || err !== 1'b1 || rd !== 32'd0 || psel_cycles !== 0) begin
      miscompares++;
      $display("FAIL bad_op: got lat=%0d err=%b data=%h psel=%0d, required 1 1 0 0", lat, err, rd, psel_cycles);
    end
  endtask

  task automatic test_slverr();
    int lat; logic err; logic [31:0] rd, d;
    d = $urandom;
    slverr_addr = 1;
    log_q.delete();
    model(3'd2, d, 1'b0);
    run_cmd(3'd2, d, 1'b0, lat, err, rd);
    vectors++;
    if (lat !== exp_lat || err !== 1'b1 || !log_ok()) begin
      miscompares++;
      $display("FAIL slverr: got lat=%0d err=%b writes=%0d, required %0d 1 %0d", lat, err, log_q.size(), exp_lat, exp_q.size());
    end
    slverr_addr = -1;
  endtask

  task automatic test_random();
    int lat; logic err; logic [31:0] rd, d, exp_d;
    logic [2:0] op;
    logic ien;
    for (int n = 0; n < 24; n++) begin
      op = 3'($urandom_range(0, 5));
      d = $urandom;
      ien = 1'($urandom);
      stall_addr = $urandom_range(0, 4);
      stall_cyc = $urandom_range(0, 5);
      foreach (rd_regs[i]) rd_regs[i] = $urandom;
      log_q.delete();
      model(op, d, ien);
      exp_d = exp_rd ? rd_regs[exp_rd_a] : 32'd0;
      run_cmd(op, d, ien, lat, err, rd);
      vectors++;
      if (lat !== exp_lat || err !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_rsp op=%0d: got lat=%0d err=%b, required %0d 0", op, lat, err, exp_lat);
      end
      vectors++;
      if (rd !== exp_d) begin
        miscompares++;
        $display("FAIL rand_data op=%0d: got %h, required %h", op, rd, exp_d);
      end
      vectors++;
      if (!log_ok()) begin
        miscompares++;
        $display("FAIL rand_writes op=%0d: got %0d writes, required %0d", op, log_q.size(), exp_q.size());
      end
    end
    stall_addr = -1; stall_cyc = 0;
  endtask

  task automatic test_async_reset();
    int rsp0;
    stuck = 1'b1;
    cmd_op = 3'd0; cmd_data = 32'hABCD; cmd_ien = 1'b1; cmd_valid = 1'b1;
    #1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !m_penable; i++) @(negedge clk);
    #1 PRESETn = 1'b0;
    #1;
    vectors++;
    if ({m_psel, m_penable, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_rst: got psel/pen/busy=%b, required 000", {m_psel, m_penable, busy});
    end
    rsp0 = rsp_count;
    @(negedge clk);
    PRESETn = 1'b1;
    stuck = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || irq_cnt !== 2'd0 || rsp_count !== rsp0) begin
      miscompares++;
      $display("FAIL post_rst: got ready=%b cnt=%0d rsp=%0d, required 1 0 0", cmd_ready, irq_cnt, rsp_count - rsp0);
    end
  endtask

  initial begin
    foreach (rd_regs[i]) rd_regs[i] = 32'd0;
    test_reset();
    test_start();
    test_stall();
    test_read();
    test_arb();
    test_sat();
    test_timeout();
    test_slverr();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000");
    $fatal(1);
  end
endmodule
